// File: rtl/memory_sweep_ram.sv
// Synchronous RAM with one write port, a registered random-read port and a
// sweep engine that streams every word over a valid/ready port.
module memory_sweep_ram #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              fetch;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_X);

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_ok ? mem[rd_addr] : '0;
            end
        end
    end

    // Sweep fetch shares the array read port; it only fires when rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (fetch) begin
            out_data <= mem[ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fetch      = 1'b0;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = FETCH;
                    ptr_d   = '0;
                end
            end
            FETCH: begin
                sweep_busy = 1'b1;
                if (!rd_en) begin
                    fetch   = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                sweep_busy = 1'b1;
                out_valid  = 1'b1;
                if (out_ready) begin
                    if (ptr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_addr = ptr_q;

endmodule

// File: tb/tb_memory_sweep_ram.sv
// Directed bench for memory_sweep_ram: a default 16-word instance and a
// 10-word instance with a 4-bit address.
module tb_memory_sweep_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;

    logic       wr_en = 1'b0, rd_en = 1'b0, sweep_start = 1'b0, out_ready = 1'b0;
    logic [3:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [3:0] rd_data, out_addr, out_data;
    logic       rd_valid, sweep_busy, sweep_done, out_valid;

    logic       b_wr_en = 1'b0, b_rd_en = 1'b0, b_sweep_start = 1'b0, b_out_ready = 1'b0;
    logic [3:0] b_wr_addr = '0, b_wr_data = '0, b_rd_addr = '0;
    logic [3:0] b_rd_data, b_out_addr, b_out_data;
    logic       b_rd_valid, b_sweep_busy, b_sweep_done, b_out_valid;

    memory_sweep_ram dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
    );

    memory_sweep_ram #(.DATA_W(4), .ADDR_W(4), .DEPTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .sweep_start(b_sweep_start), .sweep_busy(b_sweep_busy), .sweep_done(b_sweep_done),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr),
        .out_data(b_out_data)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] model   [16];
    logic [3:0] model10 [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic rd_check(input logic [3:0] a);
        logic [3:0] exp;
        exp = model[a];
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check("rd_valid_pulse", rd_valid, 1);
        check("rd_data", rd_data, exp);
        tick();
        check("rd_valid_single", rd_valid, 0);
        check("rd_data_hold", rd_data, exp);
    endtask

    task automatic sweep_main(input int exp_words, input int exp_cyc);
        int nxt = 0;
        int cyc = 0;
        bit seen_done = 0;
        bit overlap = 0;
        sweep_start = 1'b1; out_ready = 1'b1;
        while (!seen_done && cyc < 200) begin
            tick();
            sweep_start = 1'b0;
            cyc++;
            if (sweep_busy && sweep_done) overlap = 1;
            if (sweep_done) seen_done = 1;
            else if (out_valid) begin
                check("sweep_addr", out_addr, nxt);
                check("sweep_data", out_data, model[nxt]);
                nxt++;
            end
        end
        check("sweep_done_seen", seen_done, 1);
        check("sweep_cycles", cyc, exp_cyc);
        check("sweep_words", nxt, exp_words);
        check("busy_done_overlap", overlap, 0);
        tick();
        check("post_sweep_busy", sweep_busy, 0);
        check("post_sweep_done", sweep_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: all outputs low
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst10_out_valid", b_out_valid, 0);
        tick(); tick();
        rst_n = 1'b1;

        // 1: fill and read back
        for (int i = 0; i < 16; i++) wr(4'(i), 4'(i) ^ 4'hA);
        for (int i = 0; i < 16; i++) rd_check(4'(i));

        // 2: read-first collision at address 3
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd5;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; model[3] = 4'd5;
        check("collide_old", rd_data, 4'h9);
        check("collide_valid", rd_valid, 1);
        rd_check(4'd3);
        check("collide_new", rd_data, 4'h5);

        // 3: free-running sweep
        sweep_main(16, 33);

        // 4: backpressure, interleaved reads, mid-sweep write and ignored start
        begin
            int         nxt, c;
            bit         done4, pend_rd, held;
            logic [3:0] pend_exp, h_addr, h_data;
            nxt = 0; c = 0; done4 = 0; pend_rd = 0; held = 0;
            pend_exp = '0; h_addr = '0; h_data = '0;
            sweep_start = 1'b1; out_ready = 1'b0;
            tick();
            sweep_start = 1'b0;
            while (c < 400) begin
                if (pend_rd) begin
                    check("bp_rd_valid", rd_valid, 1);
                    check("bp_rd_data", rd_data, pend_exp);
                end else begin
                    check("bp_rd_idle", rd_valid, 0);
                end
                if (held) begin
                    check("bp_hold_valid", out_valid, 1);
                    check("bp_hold_addr", out_addr, h_addr);
                    check("bp_hold_data", out_data, h_data);
                end
                if (sweep_done) begin
                    done4 = 1;
                    break;
                end
                out_ready   = (c % 2 == 0);
                rd_en       = (c % 3 == 0);
                rd_addr     = 4'(c);
                pend_rd     = rd_en;
                pend_exp    = rd_en ? model[rd_addr] : 4'h0;
                sweep_start = (c == 8);
                if (c == 4) begin
                    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 4'd6; model[14] = 4'd6;
                end else begin
                    wr_en = 1'b0;
                end
                held   = out_valid && !out_ready;
                h_addr = out_addr;
                h_data = out_data;
                if (out_valid && out_ready) begin
                    check("bp_addr", out_addr, nxt);
                    check("bp_data", out_data, model[nxt]);
                    nxt++;
                end
                tick();
                c++;
            end
            wr_en = 1'b0; rd_en = 1'b0; sweep_start = 1'b0;
            check("bp_done_seen", done4, 1);
            check("bp_words", nxt, 16);
            tick(); tick(); tick();
            check("bp_start_not_queued", sweep_busy, 0);
        end

        // 5: DEPTH=10 instance
        for (int i = 0; i < 10; i++) begin
            b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = 4'(i) ^ 4'h5;
            model10[i] = 4'(i) ^ 4'h5;
            tick();
        end
        b_wr_addr = 4'd12; b_wr_data = 4'hF;
        tick();
        b_wr_en = 1'b0;
        b_rd_en = 1'b1; b_rd_addr = 4'd12;
        tick();
        b_rd_en = 1'b0;
        check("d10_oor_valid", b_rd_valid, 1);
        check("d10_oor_data", b_rd_data, 0);
        begin
            int nxt, cyc;
            bit seen;
            nxt = 0; cyc = 0; seen = 0;
            b_sweep_start = 1'b1; b_out_ready = 1'b1;
            while (!seen && cyc < 200) begin
                tick();
                b_sweep_start = 1'b0;
                cyc++;
                if (b_sweep_done) seen = 1;
                else if (b_out_valid) begin
                    check("d10_addr", b_out_addr, nxt);
                    check("d10_data", b_out_data, (nxt < 10) ? model10[nxt] : 4'hx);
                    nxt++;
                end
            end
            check("d10_done_seen", seen, 1);
            check("d10_words", nxt, 10);
            check("d10_cycles", cyc, 21);
        end

        // 6: asynchronous reset while presenting address 5
        begin
            int  cyc;
            bit  found;
            cyc = 0; found = 0;
            sweep_start = 1'b1; out_ready = 1'b1;
            while (!found && cyc < 100) begin
                tick();
                sweep_start = 1'b0;
                cyc++;
                if (out_valid && out_addr == 4'd5) found = 1;
            end
            out_ready = 1'b0;
            check("abort_found_addr5", found, 1);
            #2 rst_n = 1'b0;
            #1;
            check("abort_out_valid", out_valid, 0);
            check("abort_busy", sweep_busy, 0);
            check("abort_done", sweep_done, 0);
            check("abort_out_addr", out_addr, 0);
            check("abort_out_data", out_data, 0);
            check("abort_rd_data", rd_data, 0);
            check("abort_rd_valid", rd_valid, 0);
            tick();
            rst_n = 1'b1;
            tick();
            check("abort_no_done", sweep_done, 0);
            rd_check(4'd7);
            rd_check(4'd5);
            sweep_main(16, 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
